// File: rtl/reflex_round_ctrl.sv
// Round sequencer for the reflex trainer: gap, spawn, show, then time the
// player's reaction until a hit or timeout, tallying hits/misses and reaction times.
module reflex_round_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int ROUNDS     = 10,
  parameter int GAP_MS     = 500,
  parameter int TIMEOUT_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit,
  output logic        spawn,
  output logic        ball_visible,
  output logic [7:0]  hits,
  output logic [7:0]  misses,
  output logic [7:0]  round_idx,
  output logic [11:0] last_ms,
  output logic [11:0] best_ms,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    SPAWN = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [11:0]     GAP_LAST   = 12'(GAP_MS - 1);
  localparam logic [11:0]     SHOW_LAST  = 12'(TIMEOUT_MS - 1);
  localparam logic [7:0]      ROUND_END  = 8'(ROUNDS);

  state_t        cur, nxt;
  logic [PW-1:0] presc;
  logic [11:0]   ms_cnt;
  logic          start_q;
  logic          start_edge;
  logic          tick;
  logic          hit_ev;
  logic          timeout_ev;
  logic          restart;
  logic [7:0]    round_next;

  assign state = cur;

  // A hit wins over a timeout landing in the same cycle.
  always_comb begin
    start_edge = start & ~start_q;
    tick       = (presc == PRESC_LAST);
    hit_ev     = (cur == SHOW) && hit;
    timeout_ev = (cur == SHOW) && !hit && tick && (ms_cnt == SHOW_LAST);
    restart    = ((cur == IDLE) || (cur == DONE)) && start_edge;
    round_next = round_idx + 8'd1;
    nxt        = cur;
    case (cur)
      IDLE, DONE: if (start_edge) nxt = GAP;
      GAP:        if (tick && (ms_cnt == GAP_LAST)) nxt = SPAWN;
      SPAWN:      nxt = SHOW;
      SHOW:       if (hit_ev || timeout_ev) nxt = (round_next == ROUND_END) ? DONE : GAP;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur          <= IDLE;
      presc        <= '0;
      ms_cnt       <= '0;
      start_q      <= 1'b0;
      hits         <= '0;
      misses       <= '0;
      round_idx    <= '0;
      last_ms      <= '0;
      best_ms      <= 12'hFFF;
      spawn        <= 1'b0;
      ball_visible <= 1'b0;
      done         <= 1'b0;
    end else begin
      cur          <= nxt;
      start_q      <= start;
      spawn        <= (nxt == SPAWN);
      ball_visible <= (nxt == SHOW);
      done         <= (nxt == DONE);

      // The millisecond timebase restarts from zero on entry to every state.
      if (nxt != cur) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && (ms_cnt != 12'hFFF)) ms_cnt <= ms_cnt + 12'd1;
      end

      if (restart) begin
        hits      <= '0;
        misses    <= '0;
        round_idx <= '0;
        last_ms   <= '0;
      end else if (hit_ev) begin
        hits      <= hits + 8'd1;
        round_idx <= round_next;
        last_ms   <= ms_cnt;
        if (ms_cnt < best_ms) best_ms <= ms_cnt;
      end else if (timeout_ev) begin
        misses    <= misses + 8'd1;
        round_idx <= round_next;
      end
    end
  end

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Directed bench for reflex_round_ctrl with TICK_DIV=4, GAP_MS=3, TIMEOUT_MS=5, ROUNDS=3:
// GAP is 12 cycles, SHOW times out after 20 cycles, ms_cnt = SHOW cycle index / 4.
module tb_reflex_round_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hit;
  logic        spawn;
  logic        ball_visible;
  logic [7:0]  hits;
  logic [7:0]  misses;
  logic [7:0]  round_idx;
  logic [11:0] last_ms;
  logic [11:0] best_ms;
  logic        done;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  reflex_round_ctrl #(
    .TICK_DIV(4),
    .ROUNDS(3),
    .GAP_MS(3),
    .TIMEOUT_MS(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .hit(hit),
    .spawn(spawn),
    .ball_visible(ball_visible),
    .hits(hits),
    .misses(misses),
    .round_idx(round_idx),
    .last_ms(last_ms),
    .best_ms(best_ms),
    .done(done),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".state"}, 32'(state), 0);
    check_output({tag, ".best_ms"}, 32'(best_ms), 4095);
    check_output({tag, ".hits"}, 32'(hits), 0);
    check_output({tag, ".misses"}, 32'(misses), 0);
    check_output({tag, ".round_idx"}, 32'(round_idx), 0);
    check_output({tag, ".last_ms"}, 32'(last_ms), 0);
    check_output({tag, ".spawn"}, 32'(spawn), 0);
    check_output({tag, ".ball_visible"}, 32'(ball_visible), 0);
    check_output({tag, ".done"}, 32'(done), 0);
  endtask

  task automatic check_score(input string tag, input int e_hits, input int e_misses,
                             input int e_round, input int e_last, input int e_best, input int e_state);
    check_output({tag, ".hits"}, 32'(hits), 32'(e_hits));
    check_output({tag, ".misses"}, 32'(misses), 32'(e_misses));
    check_output({tag, ".round_idx"}, 32'(round_idx), 32'(e_round));
    check_output({tag, ".last_ms"}, 32'(last_ms), 32'(e_last));
    check_output({tag, ".best_ms"}, 32'(best_ms), 32'(e_best));
    check_output({tag, ".state"}, 32'(state), 32'(e_state));
    check_output({tag, ".ball_visible"}, 32'(ball_visible), 0);
  endtask

  // From GAP entry: 12 GAP cycles, one SPAWN cycle, then SHOW.
  task automatic gap_to_show(input string tag);
    apply_stimulus(12);
    check_output({tag, ".spawn"}, 32'(spawn), 1);
    check_output({tag, ".spawn_state"}, 32'(state), 2);
    apply_stimulus(1);
    check_output({tag, ".visible"}, 32'(ball_visible), 1);
    check_output({tag, ".spawn_fall"}, 32'(spawn), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    hit = 1'b0;

    $display("[TB] reset");
    apply_stimulus(3);
    rst = 1'b1;
    check_reset_values("reset");

    $display("[TB] hit in IDLE is ignored");
    hit = 1'b1;
    apply_stimulus(1);
    hit = 1'b0;
    check_output("idle_hit.state", 32'(state), 0);
    check_output("idle_hit.hits", 32'(hits), 0);

    $display("[TB] game 1, round 1: start, GAP with stray start edge and hit");
    start = 1'b1;
    apply_stimulus(1);
    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("gap1.state[%0d]", i), 32'(state), 1);
      check_output($sformatf("gap1.spawn[%0d]", i), 32'(spawn), 0);
      start = !((i == 4) || (i == 5));
      hit = (i == 8);
      apply_stimulus(1);
    end
    hit = 1'b0;
    check_output("spawn1.state", 32'(state), 2);
    check_output("spawn1.spawn", 32'(spawn), 1);
    check_output("spawn1.visible", 32'(ball_visible), 0);
    hit = 1'b1;
    apply_stimulus(1);
    hit = 1'b0;
    check_output("show1.state", 32'(state), 3);
    check_output("show1.spawn", 32'(spawn), 0);
    check_output("show1.visible", 32'(ball_visible), 1);
    check_output("show1.hits", 32'(hits), 0);

    start = 1'b0;
    apply_stimulus(2);
    start = 1'b1;
    apply_stimulus(6);
    hit = 1'b1;
    apply_stimulus(1);
    hit = 1'b0;
    check_score("hit1", 1, 0, 1, 2, 2, 1);

    $display("[TB] game 1, round 2: faster hit");
    gap_to_show("r2");
    apply_stimulus(4);
    hit = 1'b1;
    apply_stimulus(1);
    hit = 1'b0;
    check_score("hit2", 2, 0, 2, 1, 1, 1);

    $display("[TB] game 1, round 3: timeout ends the game");
    gap_to_show("r3");
    for (int j = 0; j < 20; j++) begin
      check_output($sformatf("show3.state[%0d]", j), 32'(state), 3);
      apply_stimulus(1);
    end
    check_score("timeout_last", 2, 1, 3, 1, 1, 4);
    check_output("timeout_last.done", 32'(done), 1);

    hit = 1'b1;
    apply_stimulus(1);
    hit = 1'b0;
    apply_stimulus(1);
    check_score("done_hit", 2, 1, 3, 1, 1, 4);
    check_output("done_hit.done", 32'(done), 1);

    $display("[TB] restart");
    start = 1'b0;
    apply_stimulus(1);
    start = 1'b1;
    apply_stimulus(1);
    check_score("restart", 0, 0, 0, 0, 1, 1);
    check_output("restart.done", 32'(done), 0);

    $display("[TB] game 2, round 1: timeout mid-game");
    gap_to_show("g2r1");
    apply_stimulus(20);
    check_score("timeout_mid", 0, 1, 1, 0, 1, 1);

    $display("[TB] game 2, round 2: hit colliding with timeout");
    gap_to_show("g2r2");
    apply_stimulus(19);
    hit = 1'b1;
    apply_stimulus(1);
    hit = 1'b0;
    check_score("collide", 1, 1, 2, 4, 1, 1);

    $display("[TB] reset during SHOW with start held high");
    gap_to_show("g2r3");
    apply_stimulus(3);
    rst = 1'b0;
    apply_stimulus(1);
    check_reset_values("mid_reset");
    rst = 1'b1;
    apply_stimulus(1);
    check_output("post_reset_start.state", 32'(state), 1);
    check_output("post_reset_start.best_ms", 32'(best_ms), 4095);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
